booth_radix4_seq_multiplier: RTL
================================

# booth_radix4_seq_multiplier

Iterative, parametrised radix-4 Booth multiplier for the ALU multiply path. It accepts one operand pair per transaction through a valid/ready handshake and retires `PP_PER_CYCLE` Booth partial products per clock into an internal accumulator. It returns the full `2*WIDTH`-bit product through a second valid/ready handshake. Each operand has its own signedness, so MUL, MULH, MULHU and MULHSU all map onto one block. It replaces the single-cycle 17-partial-product array where area matters more than latency.

## Interface
- `WIDTH`, 32: operand width. Must be even and ≥ 4.
- `PP_PER_CYCLE`, 1: partial products accumulated per clock. Legal values are 1, 2 and 4.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block can accept an operand pair.
- `a` input WIDTH: multiplicand.
- `b` input WIDTH: multiplier (the operand that is Booth-recoded).
- `a_signed` input 1: 1 means `a` is two's complement, 0 means unsigned.
- `b_signed` input 1: 1 means `b` is two's complement, 0 means unsigned.
- `kill` input 1: synchronous abort of the current transaction.
- `out_valid` output 1: `product` is valid.
- `out_ready` input 1: consumer accepts `product`.
- `product` output 2*WIDTH: full product.
- `busy` output 1: high while in state BUSY.

## Operation
- **Operand extension.**
  - Each operand is extended to WIDTH+2 bits: sign-extended if its signed flag is 1, zero-extended otherwise.
  - The extended `b` recodes into G = WIDTH/2+1 Booth digits in {-2,-1,0,+1,+2}. Digit i is taken from bits {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
- **Partial products.**
  - Partial product i = digit_i × ext(a), sign-extended to 2*WIDTH+2 bits, shifted left by 2i.
  - The accumulator is 2*WIDTH+2 bits wide.
  - `product` = accumulator[2*WIDTH-1:0]. It is exactly ext(a)×ext(b) mod 2^(2*WIDTH).
- **State machine (IDLE, BUSY, DONE).**
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`&&!`kill`: latch the operands and flags, clear the accumulator, set digit counter = 0, go to BUSY.
  - BUSY: each clock, add the partial products for digits cnt … cnt+P-1 and advance cnt by P. Digits ≥ G contribute 0. On the clock where cnt+P ≥ G, register the final sum into `product` and go to DONE.
  - DONE: `out_valid`=1 and `product` is held stable. On `out_valid`&&`out_ready`, go to IDLE.
- **Kill.**
  - `kill`=1 in BUSY or DONE: go to IDLE next clock. `out_valid` falls and no result is delivered.
  - `kill` in IDLE blocks acceptance that cycle.
  - `kill` has priority over every handshake in the same cycle.
- **Outputs per state.** `in_ready`, `out_valid` and `busy` are decoded from the state register only, with no combinational path from inputs. `in_ready` is 0 in BUSY and DONE.

## Timing
- **Reset values.** State=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `product`=0, accumulator=0, counter=0.
- **Latency.** With the input handshake at edge E0, `out_valid` rises after edge E0+C, where C = ceil(G/PP_PER_CYCLE).
  - WIDTH=32: C = 17, 9 and 5 for P = 1, 2 and 4.
- **Throughput.** One transaction per C+2 cycles when `out_ready` is held high: the acceptance cycle, then C BUSY cycles, then 1 DONE cycle.
- **Back-pressure.** DONE holds indefinitely while `out_ready`=0. `product` must not change during that time.
- **Reset mid-operation.** Asynchronous return to the reset values. Any transaction in flight is lost.

## Structure
- **Package `booth_mul_pkg`** holds:
  - the state enum (IDLE, BUSY, DONE);
  - the localparam function `booth_groups(WIDTH)` = WIDTH/2+1;
  - the Booth digit encoding (neg, one, two flags).
- **Sub-module `booth_radix4_pp_gen`** (combinational): takes a 3-bit window and ext(a), and produces one sign-extended partial product. The top instantiates it PP_PER_CYCLE times with a generate loop.
- **Parameter checks.** An elaboration-time assertion rejects odd WIDTH and any illegal PP_PER_CYCLE.

## Test plan
1. WIDTH=32, P=1, unsigned: a=5, b=3 → `product`=0x000000000000000F. `out_valid` rises exactly 17 edges after acceptance.
2. Signed/signed: a=-5, b=3 → 0xFFFFFFFFFFFFFFF1. Signed: a=b=0x80000000 → 0x4000000000000000.
3. Unsigned: a=b=0xFFFFFFFF → 0xFFFFFFFE00000001. Signed/unsigned (a_signed=1, b_signed=0): a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF00000001.
4. P=2 and P=4 builds, 1000 random operand pairs with random signedness flags:
   - every product matches the reference model;
   - latency is 9 and 5 respectively.
5. Back-pressure: hold `out_ready`=0 for 6 cycles in DONE → `product` stable, `in_ready`=0 throughout. Release → IDLE next clock and a new operand pair is accepted.
6. Abort cases:
   - `kill` at BUSY cycle 8 → IDLE next clock, and `out_valid` never rises for that transaction.
   - `rst` asserted mid-BUSY → all outputs take their reset values immediately.
   - The next transaction after either abort computes correctly.

Source files
------------

// File: rtl/booth_radix4_seq_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// booth_mul_pkg
// Shared types and helpers for the sequential radix-4 Booth multiplier:
//   - state_t        : controller states (IDLE, BUSY, DONE)
//   - booth_groups() : number of radix-4 Booth digits for a given operand width
//   - booth_digit_t  : decoded Booth digit (neg, one, two)
//   - booth_encode() : 3-bit multiplier window -> decoded digit
// -----------------------------------------------------------------------------
package booth_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The operand is extended by two bits, so WIDTH+2 bits recode into
    // WIDTH/2+1 digits.
    function automatic int booth_groups(input int width);
        return width / 2 + 1;
    endfunction

    // Digit value = (neg ? -1 : +1) * (one ? 1 : two ? 2 : 0)
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    function automatic booth_digit_t booth_encode(input logic [2:0] win);
        booth_digit_t d;
        d = '0;
        case (win)
            3'b001, 3'b010: d.one = 1'b1;                  // +1
            3'b011:         d.two = 1'b1;                  // +2
            3'b100:         begin d.neg = 1'b1; d.two = 1'b1; end  // -2
            3'b101, 3'b110: begin d.neg = 1'b1; d.one = 1'b1; end  // -1
            default:        d = '0;                        // 000 / 111 -> 0
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_radix4_seq_multiplier_if.sv
// -----------------------------------------------------------------------------
// booth_radix4_seq_multiplier_if
// Operand / result handshake bundle of the sequential Booth multiplier.
//   Request : in_valid, in_ready, a, b, a_signed, b_signed
//   Control : kill (abort), busy (status)
//   Result  : out_valid, out_ready, product
// Modports: master = producer/consumer side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface booth_radix4_seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 a_signed;
    logic                 b_signed;
    logic                 kill;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, a_signed, b_signed, kill, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, a_signed, b_signed, kill, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_radix4_pp_gen.sv
// -----------------------------------------------------------------------------
// booth_radix4_pp_gen
// Combinational radix-4 Booth partial-product generator.
//   win   : 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
//   a_ext : multiplicand already extended to WIDTH+2 bits (two's complement)
//   pp    : digit * a_ext, sign-extended to 2*WIDTH+2 bits, not yet shifted
// -----------------------------------------------------------------------------
module booth_radix4_pp_gen
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         win,
    input  logic [WIDTH+1:0]   a_ext,
    output logic [2*WIDTH+1:0] pp
);
    localparam int PP_W = 2 * WIDTH + 2;

    booth_digit_t    digit;
    logic [PP_W-1:0] a_wide;
    logic [PP_W-1:0] mag;

    // NOTE: every signal written here gets a value on every path (defaults
    // first), otherwise synthesis infers a latch.
    always_comb begin
        digit  = booth_encode(win);
        a_wide = {{WIDTH{a_ext[WIDTH+1]}}, a_ext};
        mag    = '0;
        if (digit.one) begin
            mag = a_wide;
        end else if (digit.two) begin
            mag = a_wide << 1;
        end
        pp = digit.neg ? (~mag + 1'b1) : mag;
    end
endmodule

// File: rtl/booth_radix4_seq_multiplier.sv
// -----------------------------------------------------------------------------
// booth_radix4_seq_multiplier
// Iterative radix-4 Booth multiplier retiring PP_PER_CYCLE partial products
// per clock. Per-operand signedness covers MUL / MULH / MULHU / MULHSU.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : slave side of booth_radix4_seq_multiplier_if
//          (in_valid/in_ready/a/b/a_signed/b_signed, kill,
//           out_valid/out_ready/product, busy)
// Latency: out_valid rises ceil(G/PP_PER_CYCLE) edges after acceptance,
// G = WIDTH/2+1.
// -----------------------------------------------------------------------------
module booth_radix4_seq_multiplier
    import booth_mul_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int PP_PER_CYCLE = 1
) (
    input  logic clk,
    input  logic rst,
    booth_radix4_seq_multiplier_if.slave bus
);
    localparam int G     = booth_groups(WIDTH);
    localparam int EXT_W = WIDTH + 2;
    localparam int ACC_W = 2 * WIDTH + 2;
    localparam int CNT_W = $clog2(G + PP_PER_CYCLE + 1);

    if ((WIDTH % 2 != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("booth_radix4_seq_multiplier: WIDTH must be even and >= 4");
    end
    if (!(PP_PER_CYCLE == 1 || PP_PER_CYCLE == 2 || PP_PER_CYCLE == 4)) begin : g_bad_ppc
        $error("booth_radix4_seq_multiplier: PP_PER_CYCLE must be 1, 2 or 4");
    end

    function automatic logic [EXT_W-1:0] extend(input logic [WIDTH-1:0] v, input logic s);
        return {{2{s & v[WIDTH-1]}}, v};
    endfunction

    state_t               state, state_nxt;
    logic                 accept, step, finish, last;
    logic [EXT_W-1:0]     a_ext_q;
    logic [EXT_W:0]       b_win_q;     // {ext(b), b[-1]=0}
    logic [ACC_W-1:0]     acc, acc_nxt, pp_sum;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   product_q;
    logic [ACC_W-1:0]     pp_raw   [PP_PER_CYCLE];
    logic [ACC_W-1:0]     pp_shift [PP_PER_CYCLE];

    // ---------------- partial products for digits cnt .. cnt+P-1 ----------
    for (genvar k = 0; k < PP_PER_CYCLE; k++) begin : g_pp
        logic [CNT_W-1:0] digit_idx;
        logic [2:0]       win;

        assign digit_idx = cnt + CNT_W'(k);
        // Digits past the last group contribute nothing.
        assign win = (int'(digit_idx) < G) ? 3'(b_win_q >> (2 * digit_idx)) : 3'b000;

        booth_radix4_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
            .win   (win),
            .a_ext (a_ext_q),
            .pp    (pp_raw[k])
        );

        assign pp_shift[k] = pp_raw[k] << (2 * digit_idx);
    end

    // NOTE: combinational blocks use blocking '=' so the running sum is seen
    // by the next loop iteration; clocked blocks use '<=' only.
    always_comb begin
        pp_sum = '0;
        for (int k = 0; k < PP_PER_CYCLE; k++) begin
            pp_sum = pp_sum + pp_shift[k];
        end
    end

    assign acc_nxt = acc + pp_sum;
    assign last    = (int'(cnt) + PP_PER_CYCLE) >= G;

    // ---------------- controller -------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // kill is checked first in every state so it wins over both handshakes.
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        step          = 1'b0;
        finish        = 1'b0;
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state == BUSY);
        case (state)
            IDLE: begin
                if (bus.in_valid && !bus.kill) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.kill) begin
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (last) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.kill || bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath ---------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_ext_q   <= '0;
            b_win_q   <= '0;
            acc       <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else if (accept) begin
            a_ext_q <= extend(bus.a, bus.a_signed);
            b_win_q <= {extend(bus.b, bus.b_signed), 1'b0};
            acc     <= '0;
            cnt     <= '0;
        end else if (step) begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(PP_PER_CYCLE);
            // product only changes here, so it stays frozen through DONE.
            if (finish) product_q <= acc_nxt[2*WIDTH-1:0];
        end
    end

    assign bus.product = product_q;
endmodule
